int_sub_serial: RTL and testbench

- Digit-serial signed integer subtractor: x = a - b for two's-complement operands of independent widths.
- Full-precision result, one extra bit over the wider operand, so overflow cannot occur.
- Processes DIGIT_W bits per cycle through a single narrow adder with ripple borrow across cycles.
- Valid/ready handshakes on input and output; trades latency for area in datapaths that need difference terms alongside the combinational adder.

---
 rtl/int_sub_serial.sv | 100 ++++++++++
 tb/tb_int_sub_serial.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sub_serial.sv
// Digit-serial signed subtractor: x = a - b, DIGIT_W bits per cycle through one
// narrow adder, borrow rippled across cycles as a carry with an inverted subtrahend.
module int_sub_serial #(
  parameter int W_IN_A  = 8,
  parameter int W_IN_B  = 16,
  parameter int DIGIT_W = 4,
  localparam int W_MAX_OP   = (W_IN_A > W_IN_B) ? W_IN_A : W_IN_B,
  localparam int W_OUT_X    = W_MAX_OP + 1,
  localparam int NUM_DIGITS = (W_OUT_X + DIGIT_W - 1) / DIGIT_W,
  localparam int W_PAD      = NUM_DIGITS * DIGIT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [W_IN_A-1:0]  in_a,
  input  logic signed [W_IN_B-1:0]  in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [W_OUT_X-1:0] out_x,
  output logic                      busy
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [W_PAD-1:0]   op_a_q, op_b_q;
  logic        [W_PAD-1:0]   res_q, res_next;
  logic                      carry_q;
  logic        [CNT_W-1:0]   cnt_q;
  logic        [DIGIT_W:0]   sum;
  logic signed [W_PAD-1:0]   a_ext, b_ext;
  logic                      last_digit;

  assign a_ext = {{(W_PAD - W_IN_A){in_a[W_IN_A-1]}}, in_a};
  assign b_ext = {{(W_PAD - W_IN_B){in_b[W_IN_B-1]}}, in_b};

  // One digit of a + ~b + carry; the initial carry of 1 completes the negation of b.
  assign sum = {1'b0, op_a_q[DIGIT_W-1:0]} + {1'b0, op_b_q[DIGIT_W-1:0]}
             + {{DIGIT_W{1'b0}}, carry_q};

  // New digit enters at the top so digit 0 ends up at bit 0 after the last shift.
  generate
    if (DIGIT_W < W_PAD) begin : g_shift
      assign res_next = {sum[DIGIT_W-1:0], res_q[W_PAD-1:DIGIT_W]};
    end else begin : g_whole
      assign res_next = sum[DIGIT_W-1:0];
    end
  endgenerate

  assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          op_a_q  <= a_ext;
          op_b_q  <= ~b_ext;
          carry_q <= 1'b1;
          cnt_q   <= '0;
          res_q   <= '0;
        end
        RUN: begin
          res_q   <= res_next;
          carry_q <= sum[DIGIT_W];
          op_a_q  <= op_a_q >> DIGIT_W;
          op_b_q  <= op_b_q >> DIGIT_W;
          cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_x     = res_q[W_OUT_X-1:0];

endmodule

// File: tb/tb_int_sub_serial.sv
// Bench for int_sub_serial: three instances (DIGIT_W = 4, 1, 17) share stimulus;
// a scoreboard queues a-b per accepted pair and a monitor pops on each output handshake.
module tb_int_sub_serial;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_a = '0;
  logic [15:0] in_b = '0;

  logic        in_ready_v  [NI];
  logic        out_valid_v [NI];
  logic        busy_v      [NI];
  logic [16:0] out_x_v     [NI];

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  logic [16:0] q0[$], q1[$], q2[$];
  logic [16:0] hold     [NI];
  bit          hold_vld [NI];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      int_sub_serial #(
        .W_IN_A (8),
        .W_IN_B (16),
        .DIGIT_W((g == 0) ? 4 : ((g == 1) ? 1 : 17))
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready_v[g]),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid_v[g]),
        .out_ready(out_ready),
        .out_x    (out_x_v[g]),
        .busy     (busy_v[g])
      );
    end
  endgenerate

  // Digits per operation for a 17-bit result: ceil(17/4), ceil(17/1), ceil(17/17).
  function automatic int nd(int k);
    return (k == 0) ? 5 : ((k == 1) ? 17 : 1);
  endfunction

  function automatic logic [16:0] model(logic [7:0] a, logic [15:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    return d[16:0];
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual %0h required %0h", name, k, act, exp);
    end
  endtask

  task automatic q_push(int k, logic [16:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int q_size(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_pop(int k, output logic [16:0] v);
    case (k)
      0: v = q0.pop_front();
      1: v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic q_clear(int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic monitor();
    logic [16:0] e;
    while (!done) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          q_clear(k);
          hold_vld[k] = 1'b0;
        end else begin
          if (out_valid_v[k]) begin
            if (hold_vld[k]) chk("held_out_x", k, 32'(out_x_v[k]), 32'(hold[k]));
            if (out_ready) begin
              if (q_size(k) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output dut%0d actual %0h required none", k, out_x_v[k]);
              end else begin
                q_pop(k, e);
                chk("result", k, 32'(out_x_v[k]), 32'(e));
              end
              hold_vld[k] = 1'b0;
            end else begin
              hold[k]     = out_x_v[k];
              hold_vld[k] = 1'b1;
            end
          end else begin
            hold_vld[k] = 1'b0;
          end
          if (in_valid && in_ready_v[k]) q_push(k, model(in_a, in_b));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(string name);
    for (int k = 0; k < NI; k++) begin
      chk({name, "_in_ready"}, k, 32'(in_ready_v[k]), 32'd1);
      chk({name, "_out_valid"}, k, 32'(out_valid_v[k]), 32'd0);
      chk({name, "_busy"}, k, 32'(busy_v[k]), 32'd0);
      chk({name, "_out_x"}, k, 32'(out_x_v[k]), 32'd0);
    end
  endtask

  task automatic op(logic [7:0] a, logic [15:0] b, logic [16:0] exp, string name);
    int lat[NI];
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < NI; k++) lat[k] = -1;
    for (int s = 1; s <= 24; s++) begin
      step();
      for (int k = 0; k < NI; k++)
        if (out_valid_v[k] && lat[k] < 0) begin
          lat[k] = s;
          chk(name, k, 32'(out_x_v[k]), 32'(exp));
        end
    end
    for (int k = 0; k < NI; k++) chk({name, "_latency"}, k, 32'(lat[k]), 32'(nd(k)));
  endtask

  task automatic stimulus();
    logic [16:0] held;
    int last[NI];

    // Reset state
    rst_n = 1'b0;
    step(); step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Directed operands with known differences
    op(8'h05, 16'h0003, 17'h00002, "basic");
    op(8'h80, 16'h7FFF, 17'h17F81, "neg_extreme");
    op(8'h7F, 16'h8000, 17'h0807F, "pos_extreme");
    op(8'hFF, 16'hFFFF, 17'h00000, "minus1_minus1");

    // Backpressure in DONE with operands changing underneath
    out_ready = 1'b0; in_a = 8'h33; in_b = 16'h1234; in_valid = 1'b1;
    step();
    for (int s = 0; s < 40; s++) begin
      if (out_valid_v[0]) break;
      step();
    end
    chk("bp_reach_done", 0, 32'(out_valid_v[0]), 32'd1);
    held = out_x_v[0];
    chk("bp_value", 0, 32'(held), 32'(17'h1EDFF));
    for (int s = 0; s < 10; s++) begin
      in_a = 8'($urandom);
      in_b = 16'($urandom);
      step();
      chk("bp_in_ready", 0, 32'(in_ready_v[0]), 32'd0);
      chk("bp_out_valid", 0, 32'(out_valid_v[0]), 32'd1);
      chk("bp_out_x", 0, 32'(out_x_v[0]), 32'(held));
    end
    in_a = 8'h21; in_b = 16'hFFF0; out_ready = 1'b1;
    step();
    chk("bp_idle_in_ready", 0, 32'(in_ready_v[0]), 32'd1);
    chk("bp_idle_out_valid", 0, 32'(out_valid_v[0]), 32'd0);
    chk("bp_idle_out_x", 0, 32'(out_x_v[0]), 32'(held));
    step();
    chk("bp_pending_accept", 0, 32'(busy_v[0]), 32'd1);
    in_valid = 1'b0;
    for (int s = 0; s < 45; s++) step();

    // Back-to-back random pairs with both handshakes held open
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < NI; k++) last[k] = -1;
    for (int c = 0; c < 400; c++) begin
      in_a = 8'($urandom);
      in_b = 16'($urandom);
      for (int k = 0; k < NI; k++)
        if (in_ready_v[k]) begin
          if (last[k] >= 0) chk("accept_interval", k, 32'(c - last[k]), 32'(nd(k) + 2));
          last[k] = c;
        end
      step();
    end
    in_valid = 1'b0;
    for (int s = 0; s < 45; s++) step();

    // Reset in the third RUN cycle
    in_a = 8'($urandom); in_b = 16'($urandom); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("pre_abort_busy", 0, 32'(busy_v[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("abort");
    step();
    rst_n = 1'b1;
    step();
    op(8'h10, 16'h0001, 17'h0000F, "post_reset");
    for (int s = 0; s < 4; s++) step();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      hold[k]     = '0;
      hold_vld[k] = 1'b0;
    end
    fork
      monitor();
      begin
        stimulus();
        done = 1'b1;
      end
    join
    for (int k = 0; k < NI; k++) chk("scoreboard_drained", k, 32'(q_size(k)), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
